fft_reorder_ctrl: RTL
=====================

FFT_REORDER_CTRL -- requirements
Module: fft_reorder_ctrl

Interface
REQ-001 Parameter NUM_ENTRIES, default 8, sets the frame length; it SHALL be a power of two and at least 2.
REQ-002 Parameter DATA_WIDTH, default 16, sets the sample width.
REQ-003 Derived constant ENTRY_WIDTH SHALL equal $clog2(NUM_ENTRIES).
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: the upstream sample is valid.
REQ-007 Port in_data, input, DATA_WIDTH bits: sample in natural (time) order.
REQ-008 Port in_ready, output, 1 bit: the block can accept a sample this cycle.
REQ-009 Port out_valid, output, 1 bit: out_data is valid.
REQ-010 Port out_data, output, DATA_WIDTH bits: sample in bit-reversed order.
REQ-011 Port out_ready, input, 1 bit: downstream accepts a sample this cycle.
REQ-012 Port out_last, output, 1 bit: marks the final sample of a frame.
REQ-013 Port frames_done, output, 16 bits: count of completed output frames; it SHALL wrap from 0xFFFF to 0.

Function
REQ-014 The block SHALL hold two banks of NUM_ENTRIES samples (ping-pong), with one write pointer (wr_bank, wr_cnt) and one read pointer (rd_bank, rd_cnt).
REQ-015 Each bank SHALL be in state EMPTY or FULL, tracked by bank_full[1:0].
REQ-016 An input transfer SHALL occur when in_valid && in_ready; it writes in_data to bank[wr_bank][wr_cnt] and increments wr_cnt.
REQ-017 When an input transfer occurs with wr_cnt == NUM_ENTRIES-1, the block SHALL set bank_full[wr_bank], clear wr_cnt to 0 and toggle wr_bank.
REQ-018 in_ready SHALL equal !bank_full[wr_bank] (combinational; no dependency on in_valid).
REQ-019 out_valid SHALL equal bank_full[rd_bank].
REQ-020 out_data SHALL equal bank[rd_bank][bitrev(rd_cnt)], where bitrev reverses the ENTRY_WIDTH bits of the index.
REQ-021 out_last SHALL equal out_valid && (rd_cnt == NUM_ENTRIES-1).
REQ-022 An output transfer SHALL occur when out_valid && out_ready; it increments rd_cnt.
REQ-023 On an output transfer with out_last set, the block SHALL:
- clear bank_full[rd_bank];
- clear rd_cnt;
- toggle rd_bank;
- increment frames_done.
REQ-024 Latency: if the last sample of a frame is accepted at edge t, out_valid for that frame SHALL be high in the cycle following edge t.
REQ-025 Simultaneous events: a fill completion on one bank and a drain completion on the other bank in the same cycle SHALL both take effect, with no lost or duplicated sample.
REQ-026 Both banks full: in_ready SHALL be low, and in_data SHALL be ignored while it stays low.
REQ-027 When out_ready is low, out_data and out_last SHALL remain stable while out_valid is high.
REQ-028 With out_ready held at 1, the block SHALL sustain one sample per cycle on both ports, with no bubbles between frames.
REQ-029 Sample storage SHALL NOT be reset; only control state is reset.

Reset
REQ-030 On a clock edge with reset high, the block SHALL set:
- bank_full = 0;
- wr_bank = rd_bank = 0;
- wr_cnt = rd_cnt = 0;
- frames_done = 0.
REQ-031 During reset and in the cycle after it, out_valid and out_last SHALL be 0 and in_ready SHALL be 1.
REQ-032 A reset mid-frame SHALL discard any partial or full frames; the next accepted sample SHALL be index 0 of a new frame.

Structure
REQ-033 A shared package fft_pkg SHALL hold NUM_ENTRIES, ENTRY_WIDTH, DATA_WIDTH and the bitrev function, so the block reuses the existing bit-reverse index definition.
REQ-034 The storage SHALL be one sub-module, reorder_bank_ram: two banks, one write port and one asynchronous read port.
REQ-035 The control pointers and flags SHALL live in fft_reorder_ctrl.

Verification (NUM_ENTRIES = 8)
REQ-036 Single frame: input 0..7, out_ready = 1 -> output 0,4,2,6,1,5,3,7, with out_last high on the 8th output only and frames_done = 1.
REQ-037 Back-to-back frames: 24 samples with in_valid and out_ready held at 1 -> in_ready never drops, output is continuous from the cycle after the 8th input, and frames_done = 3.
REQ-038 Backpressure: out_ready = 0 while 17 samples are offered -> in_ready falls after 16 accepted; the 17th is held; after out_ready rises, the 17th is accepted on the first cycle after bank 0 drains.
REQ-039 Stall stability: out_ready toggles 1,0,0,1 during a frame -> out_data is held during the 0 cycles and the order is unchanged.
REQ-040 Reset mid-frame: reset after 5 inputs, then feed 8 new samples 10..17 -> output 10,14,12,16,11,15,13,17 with no stale data.
REQ-041 Simultaneous completion: the final input of frame 2 and the final output of frame 1 occur in the same cycle -> frame 2 output starts the next cycle and frames_done = 1 then 2.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared FFT constants and the bit-reverse index helper.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int NUM_ENTRIES = 8;
    localparam int ENTRY_WIDTH = $clog2(NUM_ENTRIES);
    localparam int DATA_WIDTH  = 16;

    // Reverses the low 'width' bits of idx; higher result bits are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
        logic [31:0] v;
        logic [31:0] r;
        v = idx;
        r = '0;
        for (int i = 0; i < width; i++) begin
            r = {r[30:0], v[0]};
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_bank_ram.sv
`default_nettype none
// ============================================================================
// Module   : reorder_bank_ram
// Brief    : Two-bank sample store, one write port, one asynchronous read port.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_bank_ram #(
    parameter int NUM_ENTRIES = fft_pkg::NUM_ENTRIES,
    parameter int DATA_WIDTH  = fft_pkg::DATA_WIDTH,
    localparam int ENTRY_WIDTH = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   i_wr_en,
    input  logic                   i_wr_bank,
    input  logic [ENTRY_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0]  i_wr_data,
    input  logic                   i_rd_bank,
    input  logic [ENTRY_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0]  o_rd_data
);
    import fft_pkg::*;

    // Bank select is the address MSB; contents are deliberately never reset.
    logic [DATA_WIDTH-1:0] r_mem [2*NUM_ENTRIES];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[{i_rd_bank, i_rd_addr}];

endmodule
`default_nettype wire

// File: rtl/fft_reorder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft_reorder_ctrl
// Brief    : Ping-pong frame buffer converting natural-order samples to
//            bit-reversed output order with valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module fft_reorder_ctrl #(
    parameter int NUM_ENTRIES = fft_pkg::NUM_ENTRIES,
    parameter int DATA_WIDTH  = fft_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [15:0]           frames_done
);
    import fft_pkg::*;

    localparam int ENTRY_WIDTH = $clog2(NUM_ENTRIES);
    localparam logic [ENTRY_WIDTH-1:0] c_last_idx = ENTRY_WIDTH'(NUM_ENTRIES - 1);

    logic [1:0]             r_bank_full;
    logic                   r_wr_bank;
    logic                   r_rd_bank;
    logic [ENTRY_WIDTH-1:0] r_wr_cnt;
    logic [ENTRY_WIDTH-1:0] r_rd_cnt;
    logic [15:0]            r_frames_done;

    logic [1:0]             w_bank_full_nxt;
    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_fill_done;
    logic                   w_drain_done;
    logic [ENTRY_WIDTH-1:0] w_rd_addr;

    // Reset forces the handshake outputs to their idle values in the reset cycle itself.
    assign in_ready     = reset || !r_bank_full[r_wr_bank];
    assign out_valid    = !reset && r_bank_full[r_rd_bank];
    assign out_last     = out_valid && (r_rd_cnt == c_last_idx);
    assign frames_done  = r_frames_done;

    assign w_in_fire    = in_valid && in_ready && !reset;
    assign w_out_fire   = out_valid && out_ready;
    assign w_fill_done  = w_in_fire && (r_wr_cnt == c_last_idx);
    assign w_drain_done = w_out_fire && out_last;
    assign w_rd_addr    = ENTRY_WIDTH'(bitrev(32'(r_rd_cnt), ENTRY_WIDTH));

    // Fill and drain always target different banks, so both updates can land together.
    always_comb begin
        w_bank_full_nxt = r_bank_full;
        if (w_fill_done) begin
            w_bank_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_drain_done) begin
            w_bank_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bank_full   <= 2'b00;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_wr_cnt      <= '0;
            r_rd_cnt      <= '0;
            r_frames_done <= 16'd0;
        end else begin
            r_bank_full <= w_bank_full_nxt;
            // Power-of-two frame length: counters wrap to zero on the last index.
            if (w_in_fire) begin
                r_wr_cnt <= r_wr_cnt + ENTRY_WIDTH'(1);
            end
            if (w_fill_done) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_out_fire) begin
                r_rd_cnt <= r_rd_cnt + ENTRY_WIDTH'(1);
            end
            if (w_drain_done) begin
                r_rd_bank     <= ~r_rd_bank;
                r_frames_done <= r_frames_done + 16'd1;
            end
        end
    end

    reorder_bank_ram #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_in_fire),
        .i_wr_bank (r_wr_bank),
        .i_wr_addr (r_wr_cnt),
        .i_wr_data (in_data),
        .i_rd_bank (r_rd_bank),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (out_data)
    );

endmodule
`default_nettype wire
